// File: rtl/avg_filter_pkg.sv
// rtl/avg_filter_pkg.sv - shared types and width helper for the moving-average filter
package avg_filter_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_UPDATE,
        S_OUT
    } state_t;

    function automatic int sum_width(input int width, input int log2_n);
        return width + log2_n;
    endfunction

endpackage

// File: rtl/avg_delay_line.sv
// rtl/avg_delay_line.sv - per-channel N-deep sample history with async clear
module avg_delay_line #(
    parameter int WIDTH  = 24,
    parameter int LOG2_N = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [LOG2_N-1:0] wptr,
    input  logic              we,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  oldest
);

    localparam int N = 1 << LOG2_N;

    logic [WIDTH-1:0] line_q [N];
    logic [WIDTH-1:0] line_d [N];

    always_comb begin
        line_d = line_q;
        if (we) begin
            line_d[wptr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                line_q[i] <= '0;
            end
        end else begin
            line_q <= line_d;
        end
    end

    // The slot about to be overwritten holds the sample leaving the window.
    assign oldest = line_q[wptr];

endmodule

// File: rtl/multichannel_avg_filter.sv
// rtl/multichannel_avg_filter.sv - multichannel boxcar average, one shared adder; AVG_FILTER_ROUND_EN selects rounding
module multichannel_avg_filter
    import avg_filter_pkg::*;
#(
    parameter int WIDTH    = 24,
    parameter int CHANNELS = 2,
    parameter int LOG2_N   = 4
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic                      primed
);

    localparam int N  = 1 << LOG2_N;
    localparam int SW = sum_width(WIDTH, LOG2_N);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CW-1:0]     LAST_CH = CW'(CHANNELS - 1);
    localparam logic [LOG2_N:0]   FILL_MAX = (LOG2_N + 1)'(N);

    state_t                           state_q, state_d;
    logic [CW-1:0]                    ch_q, ch_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   smp_q, smp_d;
    logic [WIDTH-1:0]                 oldest_q, oldest_d;
    logic signed [SW-1:0]             sum_q [CHANNELS];
    logic signed [SW-1:0]             sum_d [CHANNELS];
    logic [LOG2_N-1:0]                wptr_q, wptr_d;
    logic [LOG2_N:0]                  fill_q, fill_d;
    logic [CHANNELS-1:0][WIDTH-1:0]   out_q, out_d;

    logic [WIDTH-1:0]                 dl_oldest [CHANNELS];
    logic [WIDTH-1:0]                 cur_smp;
    logic signed [SW-1:0]             sum_new;
    logic [WIDTH-1:0]                 avg_lane;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_line
        avg_delay_line #(
            .WIDTH  (WIDTH),
            .LOG2_N (LOG2_N)
        ) u_line (
            .clk     (clk),
            .reset_n (reset_n),
            .wptr    (wptr_q),
            .we      ((state_q == S_UPDATE) && (ch_q == CW'(c))),
            .wdata   (smp_q[c]),
            .oldest  (dl_oldest[c])
        );
    end

    assign cur_smp = smp_q[ch_q];

    always_comb begin
        sum_new = sum_q[ch_q]
                + {{LOG2_N{cur_smp[WIDTH-1]}}, cur_smp}
                - {{LOG2_N{oldest_q[WIDTH-1]}}, oldest_q};
`ifdef AVG_FILTER_ROUND_EN
        // Adding N/2 before the shift only ever carries through the bit just below the cut.
        avg_lane = sum_new[LOG2_N +: WIDTH] + WIDTH'(sum_new[LOG2_N-1]);
`else
        avg_lane = sum_new[LOG2_N +: WIDTH];
`endif
    end

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        smp_d    = smp_q;
        oldest_d = oldest_q;
        sum_d    = sum_q;
        wptr_d   = wptr_q;
        fill_d   = fill_q;
        out_d    = out_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    smp_d   = in_data;
                    ch_d    = '0;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                oldest_d = dl_oldest[ch_q];
                state_d  = S_UPDATE;
            end
            S_UPDATE: begin
                sum_d[ch_q] = sum_new;
                out_d[ch_q] = avg_lane;
                if (ch_q == LAST_CH) begin
                    wptr_d  = wptr_q + 1'b1;
                    if (fill_q != FILL_MAX) begin
                        fill_d = fill_q + 1'b1;
                    end
                    state_d = S_OUT;
                end else begin
                    ch_d    = ch_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            ch_q     <= '0;
            smp_q    <= '0;
            oldest_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                sum_q[i] <= '0;
            end
            wptr_q   <= '0;
            fill_q   <= '0;
            out_q    <= '0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            smp_q    <= smp_d;
            oldest_q <= oldest_d;
            sum_q    <= sum_d;
            wptr_q   <= wptr_d;
            fill_q   <= fill_d;
            out_q    <= out_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_q;
    assign primed    = (fill_q == FILL_MAX);

endmodule
